// File: rtl/stack_alu_sequencer_pkg.sv
// Shared opcode map, sequencer state encoding and opcode classification helpers
// for the stack ALU sequencer and the ALU operations block.
package stack_alu_sequencer_pkg;

  localparam logic [3:0] OP_ADD           = 4'h0;
  localparam logic [3:0] OP_SUB           = 4'h1;
  localparam logic [3:0] OP_AND           = 4'h2;
  localparam logic [3:0] OP_OR            = 4'h3;
  localparam logic [3:0] OP_XOR           = 4'h4;
  localparam logic [3:0] OP_NAND          = 4'h5;
  localparam logic [3:0] OP_NOR           = 4'h6;
  localparam logic [3:0] OP_XNOR          = 4'h7;
  localparam logic [3:0] OP_NOT           = 4'h8;
  localparam logic [3:0] OP_EQUAL         = 4'h9;
  localparam logic [3:0] OP_NOT_EQUAL     = 4'hA;
  localparam logic [3:0] OP_GREATER       = 4'hB;
  localparam logic [3:0] OP_GREATER_EQUAL = 4'hC;
  localparam logic [3:0] OP_LESS          = 4'hD;
  localparam logic [3:0] OP_LESS_EQUAL    = 4'hE;
  localparam logic [3:0] OP_PUSH          = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_LD_A,
    ST_LD_B,
    ST_EXEC,
    ST_PUSH,
    ST_ERR
  } state_e;

  function automatic logic is_compare(input logic [3:0] op);
    return (op >= OP_EQUAL) && (op <= OP_LESS_EQUAL);
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return op == OP_NOT;
  endfunction

endpackage

// File: rtl/stack_alu_sequencer.sv
// Sequences one stack opcode at a time: fetches operands from the data stack into
// the ALU operand registers, then writes the result back or strobes the compare stack.
module stack_alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic [3:0]            op_code,
  input  logic [DATA_WIDTH-1:0] op_data,
  output logic                  op_ready,
  output logic                  op_done,
  output logic                  op_err,
  output logic [ADDR_WIDTH-1:0] stack_addr,
  output logic                  stack_we,
  output logic [DATA_WIDTH-1:0] stack_wr_data,
  input  logic [DATA_WIDTH-1:0] stack_rd_data,
  output logic [DATA_WIDTH-1:0] alu_operand,
  output logic                  ctrl_reg_op1,
  output logic                  ctrl_reg_op2,
  output logic                  ctrl_reg_overflow,
  output logic                  ctrl_stack_comp,
  output logic [3:0]            sel_ula,
  input  logic [DATA_WIDTH-1:0] ula_out,
  output logic [ADDR_WIDTH-1:0] ula_tos,
  output logic [ADDR_WIDTH:0]   tos_count
);
  import stack_alu_sequencer_pkg::*;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   tos_q, tos_d;
  logic [3:0]            opc_q, opc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] tos_lo;
  logic [ADDR_WIDTH-1:0] addr_m1;
  logic [ADDR_WIDTH-1:0] addr_m2;

  assign tos_lo  = tos_q[ADDR_WIDTH-1:0];
  assign addr_m1 = tos_lo - ADDR_WIDTH'(1);
  assign addr_m2 = tos_lo - ADDR_WIDTH'(2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tos_q   <= '0;
      opc_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      opc_q   <= opc_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    tos_d             = tos_q;
    opc_d             = opc_q;
    data_d            = data_q;
    done_d            = 1'b0;
    err_d             = 1'b0;
    op_ready          = 1'b0;
    stack_addr        = '0;
    stack_we          = 1'b0;
    stack_wr_data     = '0;
    alu_operand       = '0;
    ctrl_reg_op1      = 1'b0;
    ctrl_reg_op2      = 1'b0;
    ctrl_reg_overflow = 1'b0;
    ctrl_stack_comp   = 1'b0;
    // PUSH is not an ALU operation, so the ALU never sees 4'hF
    sel_ula           = (opc_q == OP_PUSH) ? 4'h0 : opc_q;
    ula_tos           = (tos_q == '0) ? '0 : addr_m1;

    unique case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        sel_ula  = 4'h0;
        if (op_valid) begin
          opc_d  = op_code;
          data_d = op_data;
          if (op_code == OP_PUSH) begin
            state_d = (tos_q == FULL_COUNT) ? ST_ERR : ST_PUSH;
          end else if (is_unary(op_code)) begin
            state_d = (tos_q >= (ADDR_WIDTH+1)'(1)) ? ST_RD_A : ST_ERR;
          end else begin
            state_d = (tos_q >= (ADDR_WIDTH+1)'(2)) ? ST_RD_A : ST_ERR;
          end
        end
      end
      ST_RD_A: begin
        stack_addr = addr_m1;
        state_d    = ST_LD_A;
      end
      ST_LD_A: begin
        alu_operand  = stack_rd_data;
        ctrl_reg_op1 = 1'b1;
        stack_addr   = addr_m2;
        state_d      = is_unary(opc_q) ? ST_EXEC : ST_LD_B;
      end
      ST_LD_B: begin
        alu_operand  = stack_rd_data;
        ctrl_reg_op2 = 1'b1;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_compare(opc_q)) begin
          ctrl_stack_comp = 1'b1;
          ula_tos         = addr_m2;
          tos_d           = tos_q - (ADDR_WIDTH+1)'(2);
        end else begin
          stack_we          = 1'b1;
          stack_wr_data     = ula_out;
          ctrl_reg_overflow = 1'b1;
          stack_addr        = is_unary(opc_q) ? addr_m1 : addr_m2;
          tos_d             = is_unary(opc_q) ? tos_q : tos_q - (ADDR_WIDTH+1)'(1);
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_PUSH: begin
        stack_we      = 1'b1;
        stack_addr    = tos_lo;
        stack_wr_data = data_q;
        tos_d         = tos_q + (ADDR_WIDTH+1)'(1);
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign op_done   = done_q;
  assign op_err    = err_q;
  assign tos_count = tos_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Scoreboard bench: a queue-based stack model predicts each opcode's response,
// a negedge monitor compares what the sequencer actually did when op_done fires.
module tb_stack_alu_sequencer;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [3:0]    op_code = 4'h0;
  logic [DW-1:0] op_data = '0;
  logic          op_ready, op_done, op_err;
  logic [AW-1:0] stack_addr;
  logic          stack_we;
  logic [DW-1:0] stack_wr_data;
  logic [DW-1:0] stack_rd_data = '0;
  logic [DW-1:0] alu_operand;
  logic          ctrl_reg_op1, ctrl_reg_op2, ctrl_reg_overflow, ctrl_stack_comp;
  logic [3:0]    sel_ula;
  logic [DW-1:0] ula_out;
  logic [AW-1:0] ula_tos;
  logic [AW:0]   tos_count;

  stack_alu_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_data(op_data),
    .op_ready(op_ready), .op_done(op_done), .op_err(op_err),
    .stack_addr(stack_addr), .stack_we(stack_we), .stack_wr_data(stack_wr_data),
    .stack_rd_data(stack_rd_data), .alu_operand(alu_operand),
    .ctrl_reg_op1(ctrl_reg_op1), .ctrl_reg_op2(ctrl_reg_op2),
    .ctrl_reg_overflow(ctrl_reg_overflow), .ctrl_stack_comp(ctrl_stack_comp),
    .sel_ula(sel_ula), .ula_out(ula_out), .ula_tos(ula_tos), .tos_count(tos_count)
  );

  always #5 clk = ~clk;

  // Environment: data stack RAM with registered read, and the ALU operand registers
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] alu_a = '0, alu_b = '0;

  always @(posedge clk) begin
    if (stack_we) mem[stack_addr] <= stack_wr_data;
    stack_rd_data <= mem[stack_addr];
    if (ctrl_reg_op1) alu_a <= alu_operand;
    if (ctrl_reg_op2) alu_b <= alu_operand;
  end

  // a = OP1 (top of stack), b = OP2 (next entry)
  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      4'h0: return b + a;
      4'h1: return b - a;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a & b);
      4'h6: return ~(a | b);
      4'h7: return ~(a ^ b);
      4'h8: return ~a;
      default: return '0;
    endcase
  endfunction

  assign ula_out = alu_f(sel_ula, alu_a, alu_b);

  typedef struct {
    int op; int lat; int err; int n_we; int wa; int wd; int n_cmp; int ca;
    int n_op1; int v1; int n_op2; int v2; int n_ovf; int tos; int sel;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_stack[$];
  int            checks = 0;
  int            errors = 0;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference model: decides the outcome from the stack contents alone
  function automatic exp_t predict(input logic [3:0] op, input logic [DW-1:0] d);
    exp_t e;
    int n;
    logic [DW-1:0] a, b;
    e = '{default: 0};
    n = ref_stack.size();
    e.op  = op;
    e.sel = (op == 4'hF) ? 0 : int'(op);
    e.lat = 2;
    e.err = 1;
    e.tos = n;
    if (op == 4'hF) begin
      if (n < DEPTH) begin
        e.err = 0; e.n_we = 1; e.wa = n; e.wd = d; e.tos = n + 1;
        ref_stack.push_back(d);
      end
    end else if (op == 4'h8) begin
      if (n >= 1) begin
        a = ref_stack[n-1];
        e.err = 0; e.lat = 4; e.n_op1 = 1; e.v1 = a;
        e.n_we = 1; e.wa = n - 1; e.wd = alu_f(op, a, '0); e.n_ovf = 1;
        ref_stack[n-1] = alu_f(op, a, '0);
      end
    end else if (n >= 2) begin
      a = ref_stack[n-1];
      b = ref_stack[n-2];
      e.err = 0; e.lat = 5; e.n_op1 = 1; e.v1 = a; e.n_op2 = 1; e.v2 = b;
      void'(ref_stack.pop_back());
      if (op >= 4'h9) begin
        e.n_cmp = 1; e.ca = n - 2; e.tos = n - 2;
        void'(ref_stack.pop_back());
      end else begin
        e.n_we = 1; e.wa = n - 2; e.wd = alu_f(op, a, b); e.n_ovf = 1; e.tos = n - 1;
        ref_stack[n-2] = alu_f(op, a, b);
      end
    end
    return e;
  endfunction

  // Caller is at posedge+#1; returns at posedge+#1 right after the accepting edge
  task automatic send(input logic [3:0] op, input logic [DW-1:0] d, input int gap);
    int waited;
    bit ok;
    repeat (gap) begin @(posedge clk); #1; end
    exp_q.push_back(predict(op, d));
    op_valid = 1'b1; op_code = op; op_data = d;
    waited = 0;
    ok = 0;
    while (!ok && waited < 30) begin
      @(negedge clk);
      if (op_ready) ok = 1; else waited++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code  = 4'($urandom);
    op_data  = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(op_ready && exp_q.size() == 0) && n < 30) begin
      @(negedge clk); #2; n++;
    end
    if (n >= 30) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_op_done", op_done, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_tos_count", tos_count, 0);
    chk("rst_strobes", {stack_we, ctrl_reg_op1, ctrl_reg_op2, ctrl_reg_overflow, ctrl_stack_comp}, 0);
    chk("rst_buses", {stack_addr, stack_wr_data, alu_operand, sel_ula, ula_tos}, 0);
    exp_q.delete();
    ref_stack.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: collects the strobes of the in-flight op, compares on op_done
  int cyc = 0, acc_cyc = 0;
  bit in_op = 0;
  int n_we, wa, wd, n_cmp, ca, n_op1, v1, n_op2, v2, n_ovf, sel_seen;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_op = 0;
      end else begin
        if (in_op && !op_ready) begin
          chk("strobe_exclusive",
              ((32'(ctrl_reg_op1) + 32'(ctrl_reg_op2) + 32'(stack_we) + 32'(ctrl_stack_comp)) <= 1) ? 1 : 0, 1);
          if (ctrl_reg_op1) begin n_op1++; v1 = alu_operand; end
          if (ctrl_reg_op2) begin n_op2++; v2 = alu_operand; end
          if (stack_we) begin n_we++; wa = stack_addr; wd = stack_wr_data; end
          if (ctrl_stack_comp) begin n_cmp++; ca = ula_tos; end
          if (ctrl_reg_overflow) n_ovf++;
          sel_seen = sel_ula;
        end
        if (op_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("op=%h err=%0d lat=%0d tos=%0d we=%0d@%0d=%0d cmp=%0d@%0d",
                     e.op[3:0], op_err, cyc - acc_cyc, tos_count, n_we, wa, wd, n_cmp, ca);
            chk("latency", cyc - acc_cyc, e.lat);
            chk("op_err", op_err, e.err);
            chk("op_ready_at_done", op_ready, 1);
            chk("tos_count", tos_count, e.tos);
            chk("n_stack_we", n_we, e.n_we);
            if (e.n_we == 1 && n_we == 1) begin
              chk("wr_addr", wa, e.wa);
              chk("wr_data", wd, e.wd);
            end
            chk("n_comp", n_cmp, e.n_cmp);
            if (e.n_cmp == 1 && n_cmp == 1) chk("ula_tos", ca, e.ca);
            chk("n_op1", n_op1, e.n_op1);
            if (e.n_op1 == 1 && n_op1 == 1) chk("op1_value", v1, e.v1);
            chk("n_op2", n_op2, e.n_op2);
            if (e.n_op2 == 1 && n_op2 == 1) chk("op2_value", v2, e.v2);
            chk("n_overflow", n_ovf, e.n_ovf);
            chk("sel_ula", sel_seen, e.sel);
          end
          in_op = 0;
        end
        if (op_valid && op_ready) begin
          in_op = 1; acc_cyc = cyc;
          n_we = 0; n_cmp = 0; n_op1 = 0; n_op2 = 0; n_ovf = 0;
          wa = 0; wd = 0; ca = 0; v1 = 0; v2 = 0; sel_seen = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Directed scenarios
    send(4'hF, 8'd5, 0); send(4'hF, 8'd3, 0); send(4'h0, 8'd0, 0);
    wait_idle(); do_reset();
    send(4'hF, 8'd7, 0); send(4'hF, 8'd2, 1); send(4'h1, 8'd0, 0);
    wait_idle(); do_reset();
    send(4'hF, 8'd4, 0); send(4'hF, 8'd4, 0); send(4'h9, 8'd0, 0);
    wait_idle(); do_reset();
    send(4'hF, 8'h0F, 0); send(4'h8, 8'd0, 0);
    send(4'h0, 8'd0, 2);  // underflow: only one entry
    send(4'h9, 8'd0, 0);  // underflow on compare
    wait_idle(); do_reset();
    send(4'h8, 8'd0, 0);  // NOT on empty stack
    wait_idle();

    // Randomized mix, biased towards PUSH so the stack grows
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 4) send(4'hF, DW'($urandom), $urandom_range(0, 2));
      else send(4'($urandom_range(0, 14)), DW'($urandom), $urandom_range(0, 2));
    end
    wait_idle(); do_reset();

    // Fill to capacity, then overflow
    while (ref_stack.size() < DEPTH) send(4'hF, DW'($urandom), 0);
    send(4'hF, 8'hAA, 0);
    send(4'h4, 8'd0, 0);
    send(4'hF, 8'h55, 0);
    send(4'hF, 8'h66, 0);
    send(4'hB, 8'd0, 0);
    wait_idle();

    // Reset while in LD_B: no write, no done pulse
    do_reset();
    send(4'hF, 8'd7, 0); send(4'hF, 8'd2, 0); send(4'h1, 8'd0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("post_abort_done", op_done, 0);
    chk("post_abort_tos", tos_count, 0);
    @(posedge clk); #1;

    send(4'hF, 8'd9, 0); send(4'h8, 8'd0, 0);
    wait_idle();
    chk("pending_expectations", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
